// File: rtl/tempsens_avg.sv
// rtl/tempsens_avg.sv - batch averager with running min/max for temperature-sensor results
// Optional continuous batching enabled by defining TEMPSENS_AVG_CONT_EN (adds i_cont).
module tempsens_avg #(
    parameter int RES_W  = 20,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RES_W-1:0]  i_res,
    input  logic              i_res_valid,
    input  logic              i_start,
    input  logic              i_clear,
`ifdef TEMPSENS_AVG_CONT_EN
    input  logic              i_cont,
`endif
    output logic              o_busy,
    output logic [LOG2_N:0]   o_cnt,
    output logic [RES_W-1:0]  o_avg,
    output logic              o_avg_valid,
    output logic [RES_W-1:0]  o_min,
    output logic [RES_W-1:0]  o_max
);

    localparam int ACC_W = RES_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_rnd;
    logic [ACC_W-1:0]   res_ext;
    logic               cont_req;

    assign res_ext = ACC_W'(i_res);

`ifdef TEMPSENS_AVG_CONT_EN
    assign cont_req = i_cont;
`else
    assign cont_req = 1'b0;
`endif

    // Round half up by adding half an LSB of the shifted result; no rounding for N=1.
    generate
        if (LOG2_N == 0) begin : g_no_round
            assign acc_rnd = acc;
        end else begin : g_round
            assign acc_rnd = acc + (ACC_W'(1) << (LOG2_N - 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // o_cnt is always zero in IDLE, so the same "last sample" test covers a start-cycle sample.
    always_comb begin
        state_next = state;
        o_busy     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = (i_res_valid && (o_cnt == LAST_CNT)) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                o_busy = 1'b1;
                if (i_res_valid && (o_cnt == LAST_CNT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_busy     = 1'b1;
                state_next = cont_req ? ACCUM : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            o_cnt       <= '0;
            o_avg       <= '0;
            o_avg_valid <= 1'b0;
        end else begin
            o_avg_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        acc   <= i_res_valid ? res_ext : '0;
                        o_cnt <= i_res_valid ? CNT_W'(1) : '0;
                    end
                end
                ACCUM: begin
                    if (i_res_valid) begin
                        acc   <= acc + res_ext;
                        o_cnt <= o_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    o_avg       <= RES_W'(acc_rnd >> LOG2_N);
                    o_avg_valid <= 1'b1;
                    acc         <= '0;
                    o_cnt       <= '0;
                end
                default: begin
                    acc   <= '0;
                    o_cnt <= '0;
                end
            endcase
        end
    end

    // A clear coinciding with a sample restarts tracking from that sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_min <= '1;
            o_max <= '0;
        end else if (i_clear) begin
            if (i_res_valid) begin
                o_min <= i_res;
                o_max <= i_res;
            end else begin
                o_min <= '1;
                o_max <= '0;
            end
        end else if (i_res_valid) begin
            if (i_res < o_min) begin
                o_min <= i_res;
            end
            if (i_res > o_max) begin
                o_max <= i_res;
            end
        end
    end

endmodule

// File: tb/tb_tempsens_avg.sv
// tb/tb_tempsens_avg.sv - scoreboard bench for tempsens_avg
module tb_tempsens_avg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] i_res = '0;
    logic        i_res_valid = 1'b0;
    logic        i_start = 1'b0;
    logic        i_clear = 1'b0;
`ifdef TEMPSENS_AVG_CONT_EN
    logic        i_cont = 1'b0;
`endif
    logic        o_busy;
    logic [3:0]  o_cnt;
    logic [19:0] o_avg;
    logic        o_avg_valid;
    logic [19:0] o_min;
    logic [19:0] o_max;

    typedef struct {
        logic [19:0] avg;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    tempsens_avg #(.RES_W(20), .LOG2_N(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_res       (i_res),
        .i_res_valid (i_res_valid),
        .i_start     (i_start),
        .i_clear     (i_clear),
`ifdef TEMPSENS_AVG_CONT_EN
        .i_cont      (i_cont),
`endif
        .o_busy      (o_busy),
        .o_cnt       (o_cnt),
        .o_avg       (o_avg),
        .o_avg_valid (o_avg_valid),
        .o_min       (o_min),
        .o_max       (o_max)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_avg_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL avg_pulse: unexpected o_avg_valid at cycle %0d, o_avg=%0h, required no pulse", cyc, o_avg);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (o_avg !== e.avg || cyc != e.due) begin
                    errors++;
                    $display("FAIL avg_result: got %0h at cycle %0d, required %0h at cycle %0d", o_avg, cyc, e.avg, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sample(input logic [19:0] v, input bit last, input logic [19:0] exp_avg);
        if (last) sb.push_back('{exp_avg, cyc + 2});
        i_res       = v;
        i_res_valid = 1'b1;
        tick();
        i_res_valid = 1'b0;
    endtask

    task automatic batch(input logic [19:0] base, input logic [19:0] last_v, input logic [19:0] exp_avg, input int gap);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sample((s == 7) ? last_v : base, s == 7, exp_avg);
            idle(gap);
        end
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int dropped;

        idle(2);
        reset = 1'b0;
        check("rst_busy", o_busy, 0);
        check("rst_cnt", o_cnt, 0);
        check("rst_avg", o_avg, 0);
        check("rst_avg_valid", o_avg_valid, 0);
        check("rst_min", o_min, 20'hFFFFF);
        check("rst_max", o_max, 0);

        // Basic mean, strobes spaced 3 cycles apart
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("basic_busy", o_busy, 1);
        check("basic_cnt0", o_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            sample(20'(100 + i), i == 7, 20'd104);
            if (i == 2) check("basic_cnt3", o_cnt, 3);
            idle(2);
        end
        idle(2);
        check("basic_min", o_min, 100);
        check("basic_max", o_max, 107);
        check("basic_idle", o_busy, 0);
        check("basic_cnt_end", o_cnt, 0);
        check("basic_hold", o_avg, 104);

        // Rounding edges and full-scale without wrap
        batch(20'd0, 20'd4, 20'd1, 1);
        batch(20'd0, 20'd3, 20'd0, 0);
        batch(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 0);

        // Start overlapping the first sample; a second start mid-batch is ignored
        i_start = 1'b1;
        sample(20'd50, 0, 20'd0);
        i_start = 1'b0;
        sample(20'd50, 0, 20'd0);
        sample(20'd50, 0, 20'd0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("overlap_cnt", o_cnt, 3);
        check("overlap_busy", o_busy, 1);
        for (int i = 0; i < 5; i++) sample(20'd50, i == 4, 20'd50);
        idle(3);

        // Reset mid-batch discards it
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 5; i++) sample(20'd200, 0, 20'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", o_busy, 0);
        check("midrst_cnt", o_cnt, 0);
        check("midrst_min", o_min, 20'hFFFFF);
        check("midrst_max", o_max, 0);
        check("midrst_avg", o_avg, 0);
        idle(4);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 7; i++) sample(20'd8, 0, 20'd0);
        check("fresh_cnt7", o_cnt, 7);
        check("fresh_busy", o_busy, 1);
        sample(20'd8, 1, 20'd8);
        idle(3);

        // Clear alone, tracking in IDLE, and clear colliding with a sample
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        sample(20'd10, 0, 20'd0);
        sample(20'd900, 0, 20'd0);
        check("track_min", o_min, 10);
        check("track_max", o_max, 900);
        i_clear = 1'b1;
        sample(20'd300, 0, 20'd0);
        i_clear = 1'b0;
        check("collide_min", o_min, 300);
        check("collide_max", o_max, 300);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clear_min", o_min, 20'hFFFFF);
        check("clear_max", o_max, 0);

`ifdef TEMPSENS_AVG_CONT_EN
        // Continuous batches; the DONE cycle carries no strobe
        dropped = 0;
        i_cont  = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 8; s++) begin
                if (b == 2 && s == 2) i_cont = 1'b0;
                sample(20'(1000 * (b + 1)), s == 7, 20'(1000 * (b + 1)));
                if (!o_busy) dropped = 1;
            end
            tick();
            if (b < 2) begin
                if (!o_busy) dropped = 1;
            end else begin
                check("cont_end_busy", o_busy, 0);
            end
        end
        check("cont_busy_held", dropped, 0);
        idle(2);
`else
        dropped = 0;
`endif

        idle(4);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tempsens_avg.md
Name: tempsens_avg

Overview:
- Post-processing stage directly downstream of the temperature-sensor core.
- Consumes each 20-bit conversion result the core produces (qualified by a one-cycle valid strobe) and averages a batch of 2^LOG2_N results into one rounded mean.
- Tracks the running minimum and maximum result.
- Reduces measurement noise before results are muxed onto the 8-bit output pins.

Parameters:
- RES_W, 20: result width from the sensor core.
- LOG2_N, 3: log2 of batch size N. Legal range 0..6; N=8 by default.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- i_res  input  RES_W  conversion result from the sensor core
- i_res_valid  input  1  one-cycle strobe; i_res is valid this cycle
- i_start  input  1  request a new averaging batch
- i_clear  input  1  clear min/max trackers
- o_busy  output  1  batch in progress
- o_cnt  output  LOG2_N+1  samples accepted in the current batch
- o_avg  output  RES_W  last completed rounded mean (held)
- o_avg_valid  output  1  one-cycle pulse when o_avg updates
- o_min  output  RES_W  running minimum
- o_max  output  RES_W  running maximum

Behaviour:
- Reset values (reset=1 at a clock edge):
  - state=IDLE; o_busy=0, o_cnt=0, o_avg=0, o_avg_valid=0.
  - o_min = all ones; o_max = 0; accumulator=0.
  - Reset overrides every other input.
- Accumulator width is RES_W+LOG2_N; it never overflows.
- IDLE:
  - o_busy=0.
  - i_start=1: clear the accumulator and o_cnt, go to ACCUM.
  - If i_res_valid=1 in the same cycle as i_start, that sample is the first batch sample: acc=i_res, o_cnt=1.
- ACCUM:
  - o_busy=1.
  - Each i_res_valid: acc += i_res, o_cnt += 1.
  - On the edge that accepts sample N, go to DONE.
  - i_start is ignored while in ACCUM.
- DONE (one cycle):
  - o_busy stays 1.
  - At the end edge: o_avg = (acc + 2^(LOG2_N-1)) >> LOG2_N, i.e. round half up. For LOG2_N=0, o_avg = acc.
  - Result always fits in RES_W bits; no saturation needed.
  - o_avg_valid=1 for exactly the following cycle; state→IDLE; o_cnt→0.
  - An i_res_valid arriving in the DONE cycle is not added to any batch.
- Latency: o_avg_valid is high in the second cycle after the cycle in which sample N's i_res_valid was high.
- o_avg holds its value until the next batch completes.
- Min/max tracking:
  - Updated on every i_res_valid, in any state including IDLE.
  - o_min = min(o_min, i_res); o_max = max(o_max, i_res). Comparisons are unsigned; registered, visible the next cycle.
  - i_clear alone: o_min = all ones, o_max = 0.
  - i_clear and i_res_valid in the same cycle: o_min = o_max = i_res.
- Reset mid-batch: the batch is discarded; no o_avg_valid pulse; o_avg keeps 0 after reset.
- Back-to-back i_res_valid on consecutive cycles is fully supported. No backpressure: samples are never stalled.

Optional Feature:
- Macro: TEMPSENS_AVG_CONT_EN.
- Defined:
  - Adds input port i_cont (1 bit).
  - In DONE with i_cont=1: the state goes directly to ACCUM with acc and o_cnt cleared, and o_busy stays 1 continuously.
  - o_avg and o_avg_valid behave as in single-shot mode.
  - i_cont=0 behaves exactly as single-shot.
  - Deasserting i_cont mid-batch finishes the current batch, then returns to IDLE.
- Not defined: port i_cont is absent; single-shot only.

Test Plan:
- Basic mean: LOG2_N=3, i_start, then i_res=100..107 on 8 strobes spaced 3 cycles apart → o_avg=104 (828/8=103.5, rounded up), single o_avg_valid pulse 2 cycles after the 8th strobe; o_min=100, o_max=107.
- Rounding edges: 7×0 plus 1×4 → o_avg=1; 7×0 plus 1×3 → o_avg=0; 8×0xFFFFF back-to-back → o_avg=0xFFFFF, no wrap.
- Start overlap: i_start with i_res_valid (i_res=50) same cycle, then 7×50 → o_avg=50 after exactly 8 samples. A second i_start during ACCUM is ignored; o_cnt is unaffected.
- Reset mid-batch: 5 samples, reset for 1 cycle → o_busy=0, o_cnt=0, o_min=0xFFFFF, o_max=0, no o_avg_valid. A new batch needs 8 fresh samples.
- Clear collision: after o_min=10, o_max=900, assert i_clear with i_res_valid, i_res=300 → o_min=o_max=300. i_clear alone → 0xFFFFF/0.
- TEMPSENS_AVG_CONT_EN: i_cont=1, 24 continuous strobes → 3 o_avg_valid pulses, o_busy never drops. Deassert i_cont during the 3rd batch → o_busy falls after its pulse.
